// File: rtl/tft_bus_arbiter.sv
// Request/grant arbiter sharing one tft_spi byte transmitter between N drawing engines.
// Ownership covers a whole multi-byte transaction and only changes once the transmitter is idle.
module tft_bus_arbiter #(
  parameter int N           = 4,
  parameter int ROUND_ROBIN = 0,
  parameter int HOLD_MAX    = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_dc,
  input  logic [N-1:0]   req_transmit,
  input  logic           spi_busy,
  output logic [7:0]     spi_data,
  output logic           spi_dc,
  output logic           spi_transmit,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   req_busy,
  output logic [N-1:0]   preempt,
  output logic           busy
);

  localparam int          OW         = (N > 1) ? $clog2(N) : 1;
  localparam logic [23:0] HOLD_LIMIT = 24'(HOLD_MAX);
  localparam logic [OW-1:0] LAST_IDX = OW'(N - 1);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  state_t        state, state_next;
  logic [OW-1:0] owner, last_owner, winner;
  logic          found;
  logic [23:0]   hold_cnt;
  logic [N-1:0]  grant_q;
  logic [7:0]    data_q;
  logic          dc_q;
  logic [7:0]    fwd_data;
  logic          fwd_dc, fwd_tx;
  logic          timeout;

  // Winner search: lowest index, or first index after the previous owner.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    if (ROUND_ROBIN != 0) begin
      for (int k = 0; k < N; k++) begin
        if (!found && req[(int'(last_owner) + 1 + k) % N]) begin
          winner = OW'((int'(last_owner) + 1 + k) % N);
          found  = 1'b1;
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) winner = OW'(i);
      end
    end
  end

  assign fwd_data = req_data[int'(owner)*8 +: 8];
  assign fwd_dc   = req_dc[owner];
  assign fwd_tx   = req_transmit[owner];
  assign timeout  = (HOLD_MAX != 0) && (hold_cnt >= HOLD_LIMIT) && (|(req & ~grant_q));

  // A release always wins over a simultaneous timeout, so no preempt pulse then.
  always_comb begin
    state_next = state;
    preempt    = '0;
    case (state)
      IDLE: begin
        if (|req) state_next = GRANT;
      end
      GRANT: begin
        if (!req[owner]) begin
          state_next = DRAIN;
        end else if (timeout) begin
          state_next = DRAIN;
          preempt    = grant_q;
        end
      end
      DRAIN: begin
        if (!spi_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      grant_q    <= '0;
      owner      <= '0;
      last_owner <= LAST_IDX;
      hold_cnt   <= '0;
      data_q     <= '0;
      dc_q       <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (|req) begin
            owner    <= winner;
            grant_q  <= N'(1) << winner;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          data_q <= fwd_data;
          dc_q   <= fwd_dc;
          if (hold_cnt != 24'hFF_FFFF) hold_cnt <= hold_cnt + 24'd1;
          if (state_next == DRAIN) grant_q <= '0;
        end
        DRAIN: begin
          if (!spi_busy) last_owner <= owner;
        end
        default: grant_q <= '0;
      endcase
    end
  end

  // Outside GRANT the transmitter sees the last forwarded byte with transmit held low.
  assign spi_data     = (state == GRANT) ? fwd_data : data_q;
  assign spi_dc       = (state == GRANT) ? fwd_dc : dc_q;
  assign spi_transmit = (state == GRANT) && fwd_tx;
  assign grant        = grant_q;
  assign req_busy     = {N{spi_busy}} | ~grant_q;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_tft_bus_arbiter.sv
// Directed bench for tft_bus_arbiter: dut_a runs fixed priority without a hold limit,
// dut_b runs round-robin with HOLD_MAX = 10.
module tb_tft_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_a, req_b;
  logic [31:0] req_data;
  logic [3:0]  req_dc, req_transmit;
  logic        spi_busy;

  logic [7:0]  spi_data_a, spi_data_b;
  logic        spi_dc_a, spi_dc_b, spi_transmit_a, spi_transmit_b;
  logic [3:0]  grant_a, grant_b, req_busy_a, req_busy_b, preempt_a, preempt_b;
  logic        busy_a, busy_b;

  int vector_count = 0;
  int miss_count   = 0;

  always #5 clk = ~clk;

  tft_bus_arbiter #(.N(4), .ROUND_ROBIN(0), .HOLD_MAX(0)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .req_data(req_data), .req_dc(req_dc),
    .req_transmit(req_transmit), .spi_busy(spi_busy), .spi_data(spi_data_a),
    .spi_dc(spi_dc_a), .spi_transmit(spi_transmit_a), .grant(grant_a),
    .req_busy(req_busy_a), .preempt(preempt_a), .busy(busy_a)
  );

  tft_bus_arbiter #(.N(4), .ROUND_ROBIN(1), .HOLD_MAX(10)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .req_data(req_data), .req_dc(req_dc),
    .req_transmit(req_transmit), .spi_busy(spi_busy), .spi_data(spi_data_b),
    .spi_dc(spi_dc_b), .spi_transmit(spi_transmit_b), .grant(grant_b),
    .req_busy(req_busy_b), .preempt(preempt_b), .busy(busy_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vector_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive both request vectors, then advance n clock edges (n = 0 only lets logic settle).
  task automatic applyStimulus(input logic [3:0] ra, input logic [3:0] rb, input int n);
    req_a = ra;
    req_b = rb;
    if (n == 0) #1;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int         rr_order [5] = '{0, 1, 2, 3, 0};
  logic [3:0] drop;
  logic       seen;

  initial begin
    rst = 1'b0; req_a = '0; req_b = '0; req_data = '0;
    req_dc = '0; req_transmit = '0; spi_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_grant", grant_a, 4'b0000);
    checkOutput("rst_busy", busy_a, 1'b0);
    checkOutput("rst_tx", spi_transmit_a, 1'b0);
    checkOutput("rst_data", spi_data_a, 8'h00);
    checkOutput("rst_req_busy", req_busy_a, 4'b1111);
    checkOutput("rst_grant_b", grant_b, 4'b0000);
    checkOutput("rst_preempt_b", preempt_b, 4'b0000);
    rst = 1'b1;

    // Single requester with forwarding
    req_data = 32'h00A5_0000; req_dc = 4'b0100; req_transmit = 4'b0100;
    applyStimulus(4'b0100, 4'b0000, 1);
    checkOutput("single_grant", grant_a, 4'b0100);
    checkOutput("single_data", spi_data_a, 8'hA5);
    checkOutput("single_dc", spi_dc_a, 1'b1);
    checkOutput("single_tx", spi_transmit_a, 1'b1);
    checkOutput("single_req_busy", req_busy_a, 4'b1011);
    checkOutput("single_busy", busy_a, 1'b1);
    req_transmit = 4'b0001;
    #1;
    checkOutput("non_owner_tx", spi_transmit_a, 1'b0);
    req_transmit = 4'b0000;
    applyStimulus(4'b0000, 4'b0000, 1);
    req_data = '0;
    #1;
    checkOutput("drain_grant", grant_a, 4'b0000);
    checkOutput("drain_data_held", spi_data_a, 8'hA5);
    checkOutput("drain_busy", busy_a, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 1);
    checkOutput("idle_busy", busy_a, 1'b0);

    // Fixed priority and two-cycle dead time
    applyStimulus(4'b0110, 4'b0000, 1);
    checkOutput("fp_grant", grant_a, 4'b0010);
    applyStimulus(4'b0100, 4'b0000, 1);
    checkOutput("fp_release", grant_a, 4'b0000);
    applyStimulus(4'b0100, 4'b0000, 1);
    checkOutput("fp_dead", grant_a, 4'b0000);
    applyStimulus(4'b0100, 4'b0000, 1);
    checkOutput("fp_next", grant_a, 4'b0100);
    applyStimulus(4'b0000, 4'b0000, 2);

    // Drain waits for the transmitter
    applyStimulus(4'b0001, 4'b0000, 1);
    checkOutput("dw_grant", grant_a, 4'b0001);
    spi_busy = 1'b1; req_transmit = 4'b0001;
    applyStimulus(4'b0010, 4'b0000, 1);
    for (int i = 0; i < 20; i++) begin
      checkOutput("dw_hold_grant", grant_a, 4'b0000);
      checkOutput("dw_hold_tx", spi_transmit_a, 1'b0);
      applyStimulus(4'b0010, 4'b0000, 1);
    end
    spi_busy = 1'b0; req_transmit = 4'b0000;
    applyStimulus(4'b0010, 4'b0000, 1);
    checkOutput("dw_idle", grant_a, 4'b0000);
    checkOutput("dw_idle_busy", busy_a, 1'b0);
    applyStimulus(4'b0010, 4'b0000, 1);
    checkOutput("dw_next", grant_a, 4'b0010);
    applyStimulus(4'b0000, 4'b0000, 2);

    // Round-robin rotation on dut_b
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0000, 4'b1111, 1);
      checkOutput("rr_grant", grant_b, 32'd1 << rr_order[i]);
      applyStimulus(4'b0000, 4'b1111, 2);
      drop = 4'b1111 & ~(4'(1) << rr_order[i]);
      applyStimulus(4'b0000, drop, 1);
      checkOutput("rr_release", grant_b, 4'b0000);
      applyStimulus(4'b0000, (i == 4) ? 4'b0000 : 4'b1111, 1);
    end

    // Timeout preempts owner 0 on its 11th grant cycle
    applyStimulus(4'b0000, 4'b0001, 1);
    checkOutput("to_grant", grant_b, 4'b0001);
    applyStimulus(4'b0000, 4'b1001, 0);
    for (int k = 0; k < 10; k++) begin
      checkOutput("to_early", preempt_b, 4'b0000);
      applyStimulus(4'b0000, 4'b1001, 1);
    end
    checkOutput("to_pulse", preempt_b, 4'b0001);
    checkOutput("to_still_granted", grant_b, 4'b0001);
    applyStimulus(4'b0000, 4'b1001, 1);
    checkOutput("to_pulse_end", preempt_b, 4'b0000);
    checkOutput("to_drain", grant_b, 4'b0000);
    checkOutput("to_req_busy", req_busy_b, 4'b1111);
    applyStimulus(4'b0000, 4'b1001, 2);
    checkOutput("to_next", grant_b, 4'b1000);

    // No competing request: owner 0 keeps the grant
    applyStimulus(4'b0000, 4'b0001, 3);
    checkOutput("hold_grant", grant_b, 4'b0001);
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      applyStimulus(4'b0000, 4'b0001, 1);
      if (preempt_b != 4'b0000) seen = 1'b1;
    end
    checkOutput("hold_still", grant_b, 4'b0001);
    checkOutput("hold_no_preempt", seen, 1'b0);
    applyStimulus(4'b0000, 4'b1000, 0);
    checkOutput("release_wins", preempt_b, 4'b0000);
    applyStimulus(4'b0000, 4'b1000, 1);
    checkOutput("release_drain", grant_b, 4'b0000);
    applyStimulus(4'b0000, 4'b1000, 2);
    checkOutput("release_next", grant_b, 4'b1000);

    // Reset while owner 2 holds the grant
    applyStimulus(4'b0000, 4'b0000, 2);
    req_transmit = 4'b0100;
    applyStimulus(4'b0000, 4'b0100, 1);
    checkOutput("mr_grant", grant_b, 4'b0100);
    checkOutput("mr_tx", spi_transmit_b, 1'b1);
    rst = 1'b0;
    applyStimulus(4'b0000, 4'b0100, 1);
    checkOutput("mr_grant_drop", grant_b, 4'b0000);
    checkOutput("mr_busy", busy_b, 1'b0);
    checkOutput("mr_tx_drop", spi_transmit_b, 1'b0);
    rst = 1'b1;
    applyStimulus(4'b0000, 4'b0101, 1);
    checkOutput("mr_rr_first", grant_b, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule

// File: doc/tft_bus_arbiter.md
# tft_bus_arbiter

Request/grant arbiter that shares the single `tft_spi` byte transmitter between up to N drawing engines (initializer, scene exhibitor, player, future overlays). It sits between those engines and the transmitter and forwards the granted engine's data, dc and transmit. It holds ownership for a whole multi-byte transaction and never switches owners while a byte is on the wire. It replaces the hard-wired enable-priority mux in the top level.

## Interface
Parameters:
- `N`, 4: number of requesters, 2..8.
- `ROUND_ROBIN`, 0: 0 selects fixed priority (index 0 highest); 1 selects round-robin starting after the last owner.
- `HOLD_MAX`, 0: maximum cycles an owner may hold the grant while another request is pending. 0 disables the limit. Counter width is 24 bits.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-low reset.
- `req`, in, N: per-requester bus request, level.
- `req_data`, in, 8*N: byte of requester i on bits [8i+7:8i].
- `req_dc`, in, N: dc bit per requester.
- `req_transmit`, in, N: transmit strobe per requester.
- `spi_busy`, in, 1: busy from the transmitter.
- `spi_data`, out, 8: byte forwarded to the transmitter.
- `spi_dc`, out, 1: dc forwarded to the transmitter.
- `spi_transmit`, out, 1: transmit forwarded to the transmitter.
- `grant`, out, N: one-hot grant, registered.
- `req_busy`, out, N: busy seen by requester i, equal to `spi_busy | ~grant[i]`.
- `preempt`, out, N: one-cycle pulse to an owner whose grant was revoked by the timeout.
- `busy`, out, 1: high whenever state is not IDLE.

## Operation
- States are IDLE, GRANT and DRAIN.
- **IDLE:** `grant` = 0. If `req` is nonzero, choose a winner, load `owner` and set `grant[owner]`, then go to GRANT on the next edge.
- **Winner selection, fixed priority:** lowest set index.
- **Winner selection, round-robin:** first set index scanning upward from `last_owner+1` modulo N.
- **GRANT:**
  - The forwarding mux is combinational: `spi_data` = `req_data[owner]`, `spi_dc` = `req_dc[owner]`, `spi_transmit` = `req_transmit[owner]`.
  - `hold_cnt` increments each cycle and saturates at 2^24-1.
  - `req[owner]` low → DRAIN.
  - Else if `HOLD_MAX` != 0, `hold_cnt >= HOLD_MAX`, and some other `req` bit is set → DRAIN, with a `preempt[owner]` pulse in that cycle.
- **DRAIN:**
  - `grant` = 0, `spi_transmit` = 0, and `spi_data`/`spi_dc` are held at their last forwarded values.
  - When `spi_busy` = 0, set `last_owner` = `owner` and go to IDLE.
- **Outside GRANT:** `spi_transmit` is forced to 0.
- **Preempted owner:** keeps `req` high. It is re-arbitrated normally and must restart its transaction from a resumable point, since `req_busy` stays high until it is re-granted.
- **Reset:**
  - State goes to IDLE; `grant`, `preempt`, `spi_transmit`, `spi_data` and `spi_dc` go to 0; `busy` goes to 0.
  - `hold_cnt` = 0, `owner` = 0, `last_owner` = N-1, so index 0 wins first in round-robin.
  - Reset mid-transaction drops the grant immediately. The bytes in flight are the transmitter's concern.

## Timing
- Latency from `req` rising to `grant` is 1 cycle. The first forwarded `req_transmit` is accepted in the cycle `grant` is visible.
- From `req[owner]` falling at edge t, `grant` falls at t+1.
- Once `spi_busy` = 0 is sampled in DRAIN, there is one IDLE cycle, then the next grant.
- Minimum dead time between two owners is 2 cycles.
- **Simultaneous events:**
  - Release and timeout in the same cycle: treated as a release, with no `preempt` pulse.
  - Requests arriving during DRAIN or IDLE are all considered at the IDLE edge.
- A request deasserted before it is granted is ignored.
- `req_transmit` of non-owners has no effect.
- `N` = 1 degenerates to a pass-through with the 1-cycle grant latency.

## Test plan
- **Single requester:** reset, then `req` = 4'b0100 → `grant` = 4'b0100 one cycle later. Forwarding `req_data[2]` = 8'hA5 with transmit gives `spi_data` = 8'hA5 and `spi_transmit` = 1.
- **Fixed priority:** `req` = 4'b0110 in IDLE → `grant` = 4'b0010. Release index 1 with `spi_busy` = 0 → `grant` = 4'b0100 exactly 2 cycles after `grant[1]` falls.
- **Round-robin:** `ROUND_ROBIN` = 1, `req` = 4'b1111 held, each owner releasing after 3 cycles → grant order 0, 1, 2, 3, 0.
- **Drain wait:** owner releases while `spi_busy` = 1 for 20 more cycles → `grant` = 0, `spi_transmit` = 0 throughout. The next grant comes 1 cycle after `spi_busy` falls.
- **Timeout:** `HOLD_MAX` = 10, owner 0 holds while `req[3]` is set → `preempt[0]` pulses on the 11th GRANT cycle, then `grant` = 4'b1000. With `req[3]` clear, owner 0 keeps the grant indefinitely.
- **Reset mid-grant:** `rst` = 0 for 1 cycle while owner 2 is granted → the next cycle shows `grant` = 0, `busy` = 0, `spi_transmit` = 0. With `ROUND_ROBIN` = 1 and `req` = 4'b0101, the next winner is 0.
